dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, the byte-address width of the core data port.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16, the maximum number of wait cycles for i_mem_ack.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  the asynchronous, active-high reset.
REQ-005 SHALL have port i_addr  input  ADDR_W  the core's ALU result, used as the byte address.
REQ-006 SHALL have port i_wdata  input  32  the core's rs2 store data.
REQ-007 SHALL have ports i_ld and i_sw  input  1 each  the core's load and store strobes.
REQ-008 SHALL have port i_funct3  input  3  the access size and signedness (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 SHALL have port o_rdata  output  32  the aligned, extended load data returned to the core's writeback input.
REQ-010 SHALL have port o_stall  output  1  which holds the core while an access is outstanding.
REQ-011 SHALL have port o_err  output  1  a one-cycle pulse on misalignment, conflict or timeout.
REQ-012 SHALL have memory-side outputs o_mem_req (1), o_mem_we (1), o_mem_addr (ADDR_W-2, word address), o_mem_wdata (32) and o_mem_wstrb (4).
REQ-013 SHALL have memory-side inputs i_mem_ack (1) and i_mem_rdata (32).

Function
REQ-014 SHALL implement FSM states IDLE, RD_WAIT, WR_WAIT and RESP.
REQ-015 In IDLE, an aligned i_ld SHALL drive o_stall high combinationally, register the address and funct3, and move to RD_WAIT.
REQ-016 In IDLE, an aligned i_sw SHALL register the word address, the lane-shifted data and the byte strobes, and move to WR_WAIT.
REQ-017 Strobes SHALL be: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111.
REQ-018 o_mem_req SHALL be high in every RD_WAIT/WR_WAIT cycle, with o_mem_we=1 only in WR_WAIT, and SHALL stay stable until ack is seen.
REQ-019 When i_mem_ack=1 is sampled in a WAIT state, the block SHALL move to RESP and, for loads, register o_rdata from i_mem_rdata.
REQ-020 Load data SHALL be extracted by addr[1:0] and sign- or zero-extended per funct3.
REQ-021 In RESP, o_stall SHALL be 0 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-022 Minimum load latency SHALL be 2 cycles of stall: request in cycle T, ack in T+1, data valid in RESP at T+2.
REQ-023 A misaligned access (half with addr[0]=1, or word with addr[1:0]≠0) SHALL not issue a memory request; o_err SHALL pulse, o_rdata SHALL be 0, and the FSM SHALL stay in IDLE without stalling.
REQ-024 i_ld and i_sw both high SHALL be treated as a conflict: o_err pulses and no access is issued.
REQ-025 A wait counter SHALL saturate at TIMEOUT_CYC; on reaching it, req SHALL drop, o_err SHALL pulse, load data SHALL be 0, and the FSM SHALL go to RESP.
REQ-026 i_mem_ack SHALL be ignored while o_mem_req=0.

Reset
REQ-027 Asserting reset SHALL force IDLE, with o_mem_req=0, o_mem_we=0, o_mem_wstrb=0, o_rdata=0, o_err=0 and the counter at 0, regardless of state.
REQ-028 Reset mid-transaction SHALL abandon the access; a late ack SHALL be ignored.

Configuration
REQ-029 With DMEM_STORE_BUFFER_EN defined, a store SHALL be posted: it is captured in a one-entry buffer, o_stall stays 0, and the buffer drains in WR_WAIT.
REQ-030 With DMEM_STORE_BUFFER_EN defined, any load or store arriving while the buffer drains SHALL stall until the drain ack, then be accepted.
REQ-031 Without DMEM_STORE_BUFFER_EN, a store SHALL stall like a load, through WR_WAIT and RESP.

Structure
REQ-032 Package dmem_pkg SHALL hold the FSM state encoding, the funct3 constants and the strobe patterns.
REQ-033 Sub-module dmem_load_align SHALL implement the combinational lane extraction and extension.

Verification
REQ-034 LB at addr 0x003 with word 0x80FF_1234 and ack after 1 cycle -> o_rdata=0xFFFF_FF80, 2 stall cycles.
REQ-035 SH 0x0000_BEEF at addr 0x006 -> o_mem_addr=1, o_mem_wstrb=1100, o_mem_wdata=0xBEEF_0000.
REQ-036 LW at addr 0x002 -> o_err pulse, o_mem_req stays 0, o_stall stays 0.
REQ-037 LW with no ack for 16 cycles -> req drops, o_err pulse, o_rdata=0, FSM back in IDLE two cycles later.
REQ-038 DMEM_STORE_BUFFER_EN: SW followed immediately by LW, ack delayed 3 cycles -> store cycle not stalled, load stalled until the drain completes.
REQ-039 Reset asserted in RD_WAIT, then ack pulsed -> outputs at reset values, no RESP.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM encoding, funct3 constants and strobe patterns for dmem_responder
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } dmem_state_t;

    // funct3 encodings (loads and stores share the low two size bits)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    // Size code 2'b11 has no legal access, so it is flagged like a misalignment.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = off[0];
            SZ_W:    misaligned = (off != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] strobe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    strobe = STRB_B << off;
            SZ_H:    strobe = STRB_H << off;
            default: strobe = STRB_W;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - byte-lane extraction and sign/zero extension of load data
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] lane;

    // Shift the addressed lane down to bit 0, then extend by size and signedness
    always_comb begin
        lane = i_word >> {i_off, 3'b000};
        case (i_funct3[1:0])
            SZ_B:    o_data = i_funct3[2] ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            SZ_H:    o_data = i_funct3[2] ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - core data-port responder with wait/timeout FSM; optional posted store buffer via DMEM_STORE_BUFFER_EN
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic              i_ld,
    input  logic              i_sw,
    input  logic [2:0]        i_funct3,
    output logic [31:0]       o_rdata,
    output logic              o_stall,
    output logic              o_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-3:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_wstrb,
    input  logic              i_mem_ack,
    input  logic [31:0]       i_mem_rdata
);

`ifdef DMEM_STORE_BUFFER_EN
    localparam logic POSTED = 1'b1;
`else
    localparam logic POSTED = 1'b0;
`endif

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    dmem_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [31:0]       load_data;
    logic              bad_access;

    dmem_load_align u_load_align (
        .i_word   (i_mem_rdata),
        .i_off    (addr_q[1:0]),
        .i_funct3 (funct3_q),
        .o_data   (load_data)
    );

    // Next-state, captured access fields and core stall
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        cnt_inc  = cnt_q + 1'b1;
        o_stall  = 1'b0;
        bad_access = (i_ld && i_sw) ||
                     ((i_ld || i_sw) && misaligned(i_funct3[1:0], i_addr[1:0]));
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bad_access) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (i_ld) begin
                    o_stall  = 1'b1;
                    addr_d   = i_addr;
                    funct3_d = i_funct3;
                    wstrb_d  = '0;
                    state_d  = ST_RD_WAIT;
                end else if (i_sw) begin
                    o_stall  = !POSTED;
                    addr_d   = i_addr;
                    funct3_d = i_funct3;
                    wdata_d  = i_wdata << {i_addr[1:0], 3'b000};
                    wstrb_d  = strobe(i_funct3[1:0], i_addr[1:0]);
                    state_d  = ST_WR_WAIT;
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                // A posted store only holds the core if it presents a new access.
                if (POSTED && state_q == ST_WR_WAIT) begin
                    o_stall = i_ld || i_sw;
                end else begin
                    o_stall = 1'b1;
                end
                if (i_mem_ack || cnt_inc == CNT_MAX) begin
                    if (i_mem_ack) begin
                        cnt_d = '0;
                        if (state_q == ST_RD_WAIT) rdata_d = load_data;
                    end else begin
                        cnt_d = cnt_inc;
                        err_d = 1'b1;
                        if (state_q == ST_RD_WAIT) rdata_d = '0;
                    end
                    wstrb_d = '0;
                    // A drained posted store returns straight to IDLE so a held access is taken next cycle.
                    state_d = (POSTED && state_q == ST_WR_WAIT) ? ST_IDLE : ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and access registers, cleared by the asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_rdata     = rdata_q;
    assign o_err       = err_q;
    assign o_mem_req   = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
    assign o_mem_we    = (state_q == ST_WR_WAIT);
    assign o_mem_addr  = addr_q[ADDR_W-1:2];
    assign o_mem_wdata = wdata_q;
    assign o_mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

`ifdef DMEM_STORE_BUFFER_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [11:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_ld, i_sw;
    logic [2:0]  i_funct3;
    logic [31:0] o_rdata;
    logic        o_stall, o_err;
    logic        o_mem_req, o_mem_we;
    logic [9:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.ADDR_W(12), .TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_ld        (i_ld),
        .i_sw        (i_sw),
        .i_funct3    (i_funct3),
        .o_rdata     (o_rdata),
        .o_stall     (o_stall),
        .o_err       (o_err),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_wstrb (o_mem_wstrb),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_load(input logic [11:0] a, input logic [2:0] f3,
                           input logic [31:0] word, input logic [31:0] exp);
        next_cycle();
        i_ld = 1'b1; i_sw = 1'b0; i_addr = a; i_funct3 = f3; i_mem_ack = 1'b0;
        settle();
        chk("ld_idle_stall", 32'(o_stall), 32'd1);
        chk("ld_idle_req", 32'(o_mem_req), 32'd0);
        next_cycle();
        i_mem_ack = 1'b1; i_mem_rdata = word;
        settle();
        chk("ld_wait_req", 32'(o_mem_req), 32'd1);
        chk("ld_wait_we", 32'(o_mem_we), 32'd0);
        chk("ld_wait_stall", 32'(o_stall), 32'd1);
        chk("ld_wait_addr", 32'(o_mem_addr), 32'(a >> 2));
        next_cycle();
        i_mem_ack = 1'b0; i_mem_rdata = 32'hDEAD_DEAD;
        settle();
        chk("ld_resp_stall", 32'(o_stall), 32'd0);
        chk("ld_resp_rdata", o_rdata, exp);
        chk("ld_resp_err", 32'(o_err), 32'd0);
        next_cycle();
        i_ld = 1'b0;
        settle();
        chk("ld_back_idle_req", 32'(o_mem_req), 32'd0);
    endtask

    task automatic do_store(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] d,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        next_cycle();
        i_sw = 1'b1; i_ld = 1'b0; i_addr = a; i_funct3 = f3; i_wdata = d; i_mem_ack = 1'b0;
        settle();
        chk("st_idle_stall", 32'(o_stall), SB ? 32'd0 : 32'd1);
        next_cycle();
        if (SB) i_sw = 1'b0;
        i_mem_ack = 1'b1;
        settle();
        chk("st_wait_req", 32'(o_mem_req), 32'd1);
        chk("st_wait_we", 32'(o_mem_we), 32'd1);
        chk("st_wait_addr", 32'(o_mem_addr), 32'(a >> 2));
        chk("st_wait_strb", 32'(o_mem_wstrb), 32'(exp_strb));
        chk("st_wait_wdata", o_mem_wdata, exp_wdata);
        chk("st_wait_stall", 32'(o_stall), SB ? 32'd0 : 32'd1);
        next_cycle();
        i_mem_ack = 1'b0; i_sw = 1'b0;
        settle();
        chk("st_done_req", 32'(o_mem_req), 32'd0);
        chk("st_done_stall", 32'(o_stall), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        i_addr = '0; i_wdata = '0; i_ld = 1'b0; i_sw = 1'b0; i_funct3 = '0;
        i_mem_ack = 1'b0; i_mem_rdata = '0;

        // Reset state
        next_cycle();
        settle();
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_req", 32'(o_mem_req), 32'd0);
        chk("rst_we", 32'(o_mem_we), 32'd0);
        chk("rst_strb", 32'(o_mem_wstrb), 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        next_cycle();
        reset = 1'b0;

        // Loads of every size/sign from word 0x80FF_1234
        do_load(12'h003, 3'b000, 32'h80FF_1234, 32'hFFFF_FF80);
        do_load(12'h105, 3'b100, 32'h80FF_1234, 32'h0000_0012);
        do_load(12'h00A, 3'b101, 32'h80FF_1234, 32'h0000_80FF);
        do_load(12'h00A, 3'b001, 32'h80FF_1234, 32'hFFFF_80FF);
        do_load(12'h010, 3'b001, 32'h80FF_1234, 32'h0000_1234);
        do_load(12'hFFC, 3'b010, 32'h80FF_1234, 32'h80FF_1234);

        // Stray ack with no request outstanding is ignored
        next_cycle();
        i_mem_ack = 1'b1; i_mem_rdata = 32'h1111_1111;
        settle();
        chk("stray_ack_req", 32'(o_mem_req), 32'd0);
        next_cycle();
        i_mem_ack = 1'b0;
        settle();
        chk("stray_ack_rdata", o_rdata, 32'h80FF_1234);
        chk("stray_ack_err", 32'(o_err), 32'd0);

        // Timeout: 16 wait cycles without ack
        next_cycle();
        i_ld = 1'b1; i_addr = 12'h004; i_funct3 = 3'b010;
        settle();
        chk("to_idle_stall", 32'(o_stall), 32'd1);
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            settle();
            chk($sformatf("to_wait_req_%0d", i), 32'(o_mem_req), 32'd1);
        end
        next_cycle();
        i_ld = 1'b0;
        settle();
        chk("to_resp_req", 32'(o_mem_req), 32'd0);
        chk("to_resp_err", 32'(o_err), 32'd1);
        chk("to_resp_rdata", o_rdata, 32'd0);
        chk("to_resp_stall", 32'(o_stall), 32'd0);
        do_load(12'h008, 3'b010, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Misaligned word load
        next_cycle();
        i_ld = 1'b1; i_addr = 12'h002; i_funct3 = 3'b010;
        settle();
        chk("mis_stall", 32'(o_stall), 32'd0);
        next_cycle();
        i_ld = 1'b0;
        settle();
        chk("mis_req", 32'(o_mem_req), 32'd0);
        chk("mis_err", 32'(o_err), 32'd1);
        chk("mis_rdata", o_rdata, 32'd0);
        next_cycle();
        settle();
        chk("mis_err_pulse", 32'(o_err), 32'd0);

        // Misaligned halfword store
        next_cycle();
        i_sw = 1'b1; i_addr = 12'h011; i_funct3 = 3'b001;
        settle();
        chk("mis_sh_stall", 32'(o_stall), 32'd0);
        next_cycle();
        i_sw = 1'b0;
        settle();
        chk("mis_sh_req", 32'(o_mem_req), 32'd0);
        chk("mis_sh_err", 32'(o_err), 32'd1);

        // Load/store conflict
        next_cycle();
        i_ld = 1'b1; i_sw = 1'b1; i_addr = 12'h000; i_funct3 = 3'b010;
        settle();
        chk("conf_stall", 32'(o_stall), 32'd0);
        next_cycle();
        i_ld = 1'b0; i_sw = 1'b0;
        settle();
        chk("conf_req", 32'(o_mem_req), 32'd0);
        chk("conf_err", 32'(o_err), 32'd1);

        // Stores
        do_store(12'h006, 3'b001, 32'h0000_BEEF, 4'b1100, 32'hBEEF_0000);
        do_store(12'h005, 3'b000, 32'h0000_00AB, 4'b0010, 32'h0000_AB00);
        do_store(12'h008, 3'b010, 32'h1234_5678, 4'b1111, 32'h1234_5678);

        // Reset in RD_WAIT, then a late ack
        next_cycle();
        i_ld = 1'b1; i_addr = 12'h020; i_funct3 = 3'b010;
        next_cycle();
        settle();
        chk("rstmid_req_before", 32'(o_mem_req), 32'd1);
        reset = 1'b1; i_ld = 1'b0;
        settle();
        chk("rstmid_req", 32'(o_mem_req), 32'd0);
        chk("rstmid_stall", 32'(o_stall), 32'd0);
        chk("rstmid_rdata", o_rdata, 32'd0);
        next_cycle();
        reset = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h5555_AAAA;
        settle();
        chk("rstmid_ack_req", 32'(o_mem_req), 32'd0);
        next_cycle();
        i_mem_ack = 1'b0;
        settle();
        chk("rstmid_rdata_after", o_rdata, 32'd0);
        chk("rstmid_err_after", 32'(o_err), 32'd0);
        chk("rstmid_stall_after", 32'(o_stall), 32'd0);

`ifdef DMEM_STORE_BUFFER_EN
        // Posted SW then immediate LW; store drain acked on its third wait cycle
        next_cycle();
        i_sw = 1'b1; i_addr = 12'h000; i_funct3 = 3'b010; i_wdata = 32'h1122_3344;
        settle();
        chk("sb_sw_stall", 32'(o_stall), 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            i_sw = 1'b0; i_ld = 1'b1; i_addr = 12'h004; i_funct3 = 3'b010;
            i_mem_ack = (i == 2);
            settle();
            chk($sformatf("sb_drain_stall_%0d", i), 32'(o_stall), 32'd1);
            chk($sformatf("sb_drain_we_%0d", i), 32'(o_mem_we), 32'd1);
        end
        next_cycle();
        i_mem_ack = 1'b0;
        settle();
        chk("sb_ld_accept_stall", 32'(o_stall), 32'd1);
        next_cycle();
        i_mem_ack = 1'b1; i_mem_rdata = 32'h0BAD_F00D;
        settle();
        chk("sb_ld_req", 32'(o_mem_req), 32'd1);
        chk("sb_ld_we", 32'(o_mem_we), 32'd0);
        next_cycle();
        i_mem_ack = 1'b0;
        settle();
        chk("sb_ld_stall", 32'(o_stall), 32'd0);
        chk("sb_ld_rdata", o_rdata, 32'h0BAD_F00D);
        next_cycle();
        i_ld = 1'b0;
`endif

        next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
